// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-sequencer definitions: sequencer state encodings, HALT opcode,
// register-address width and the bundle of per-stage stall/flush controls.
package mips_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_DRAIN    = 2'b10;
  localparam logic [1:0] ST_HALTED   = 2'b11;

  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } pipe_ctl_t;

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Register 0 is hard-wired zero, so it never creates a dependency.
module load_use_detector #(
  parameter int REG_AW = mips_pipe_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memtoreg,
  input  logic [REG_AW-1:0] ex_wreg,
  output logic              hazard
);

  assign hazard = ex_memtoreg && (ex_wreg != '0) &&
                  ((ex_wreg == id_rs) || (ex_wreg == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// 5-stage MIPS pipeline sequencer: memory-wait stalls, load-use interlock,
// branch/jump redirect and the HALT drain, driving pipeline-register enables/clears.
module pipeline_sequencer #(
  parameter int REG_AW      = mips_pipe_pkg::REG_AW,
  parameter int DRAIN_CYC   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_br_taken,
  input  logic              id_jump,
  input  logic              id_halt,
  input  logic              ex_memtoreg,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              halted,
  output logic              mem_err,
  output logic [1:0]        state_o
);

  import mips_pipe_pkg::*;

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          err_q, err_nxt;
  logic          hazard;
  logic          memstall;
  pipe_ctl_t     ctl;

  load_use_detector #(.REG_AW(REG_AW)) u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_memtoreg (ex_memtoreg),
    .ex_wreg     (ex_wreg),
    .hazard      (hazard)
  );

  assign memstall = mem_req && !mem_ready && (state != ST_HALTED);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    ctl       = '0;
    state_nxt = state;
    drain_nxt = drain_cnt;
    wait_nxt  = '0;
    err_nxt   = err_q;

    if (memstall) begin
      // Memory wait outranks everything; DRAIN stays put with its counter frozen.
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
      wait_nxt    = (wait_cnt == WW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WW'(1);
      if (wait_nxt == WW'(MEM_TIMEOUT)) err_nxt = 1'b1;
      if (state == ST_RUN) state_nxt = ST_MEM_WAIT;
    end else begin
      case (state)
        ST_RUN, ST_MEM_WAIT: begin
          state_nxt = ST_RUN;
          if (hazard) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
          end else if (state == ST_RUN && id_halt) begin
            ctl.stall_f = 1'b1;
            ctl.flush_d = 1'b1;
            state_nxt   = ST_DRAIN;
            drain_nxt   = DW'(DRAIN_CYC - 1);
          end else if (state == ST_RUN && (id_br_taken || id_jump)) begin
            ctl.flush_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          ctl.stall_f = 1'b1;
          ctl.flush_d = 1'b1;
          if (drain_cnt == '0) state_nxt = ST_HALTED;
          else                 drain_nxt = drain_cnt - DW'(1);
        end
        default: begin
          ctl.stall_f = 1'b1;
          ctl.stall_d = 1'b1;
          ctl.stall_e = 1'b1;
          ctl.stall_m = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      wait_cnt  <= wait_nxt;
      err_q     <= err_nxt;
    end
  end

  // Reset forces every output low immediately, independent of the held state.
  assign stall_f = !rst && ctl.stall_f;
  assign stall_d = !rst && ctl.stall_d;
  assign stall_e = !rst && ctl.stall_e;
  assign stall_m = !rst && ctl.stall_m;
  assign flush_d = !rst && ctl.flush_d;
  assign flush_e = !rst && ctl.flush_e;
  assign flush_w = !rst && ctl.flush_w;
  assign halted  = !rst && (state == ST_HALTED);
  assign mem_err = !rst && err_q;
  assign state_o = rst ? 2'b00 : state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed scenarios plus random traffic,
// checked against a behavioural model of the sequencing rules.
module tb_pipeline_sequencer;

  localparam int AW          = 5;
  localparam int DRAIN_CYC   = 4;
  localparam int MEM_TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] id_rs = '0, id_rt = '0, ex_wreg = '0;
  logic          id_br_taken = 0, id_jump = 0, id_halt = 0, ex_memtoreg = 0;
  logic          mem_req = 0, mem_ready = 0;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic          halted, mem_err;
  logic [1:0]    state_o;

  pipeline_sequencer #(.REG_AW(AW), .DRAIN_CYC(DRAIN_CYC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_br_taken(id_br_taken),
    .id_jump(id_jump), .id_halt(id_halt), .ex_memtoreg(ex_memtoreg), .ex_wreg(ex_wreg),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
    .flush_w(flush_w), .halted(halted), .mem_err(mem_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sf, sd, se, sm, fd, fe, fw, hl, er;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: mode flags plus "cycles of drain still owed" and a run-length
  // of consecutive memory-stall cycles.
  bit m_halted, m_draining, m_waiting, m_err;
  int m_drain_left, m_consec;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_draining = 0; m_waiting = 0; m_err = 0;
    m_drain_left = 0; m_consec = 0;
  endtask

  task automatic cycle(input logic r, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic br, input logic jmp, input logic hlt, input logic mtr,
                       input logic [AW-1:0] wr, input logic req, input logic rdy);
    exp_t e;
    bit   was_wait;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_br_taken = br; id_jump = jmp; id_halt = hlt;
    ex_memtoreg = mtr; ex_wreg = wr; mem_req = req; mem_ready = rdy;

    e = '{default: 1'b0, st: 2'b00};
    e.st = m_halted ? 2'd3 : m_draining ? 2'd2 : m_waiting ? 2'd1 : 2'd0;
    e.hl = m_halted;
    e.er = m_err;
    if (r) begin
      e = '{default: 1'b0, st: 2'b00};
      model_reset();
    end else if (m_halted) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1;
    end else if (req && !rdy) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
      m_consec++;
      if (m_consec >= MEM_TIMEOUT) m_err = 1;
      if (!m_draining) m_waiting = 1;
    end else begin
      m_consec = 0;
      was_wait = m_waiting;
      m_waiting = 0;
      if (m_draining) begin
        e.sf = 1; e.fd = 1;
        m_drain_left--;
        if (m_drain_left == 0) begin m_draining = 0; m_halted = 1; end
      end else if (mtr && wr != 0 && (wr == rs || wr == rt)) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end else if (!was_wait) begin
        if (hlt) begin
          e.sf = 1; e.fd = 1;
          m_draining = 1; m_drain_left = DRAIN_CYC;
        end else if (br || jmp) begin
          e.fd = 1;
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic memwait(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("stall_f", stall_f, e.sf);
      check("stall_d", stall_d, e.sd);
      check("stall_e", stall_e, e.se);
      check("stall_m", stall_m, e.sm);
      check("flush_d", flush_d, e.fd);
      check("flush_e", flush_e, e.fe);
      check("flush_w", flush_w, e.fw);
      check("halted",  halted,  e.hl);
      check("mem_err", mem_err, e.er);
      check("state_o", state_o, e.st);
    end
  end

  initial begin
    int busy;
    model_reset();
    // Reset with hazard inputs active must still show all-zero outputs.
    cycle(1, 8, 0, 1, 1, 1, 1, 8, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // T1: load-use on rs, then same pattern with ex_wreg=0.
    cycle(0, 8, 3, 0, 0, 0, 1, 8, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 2, 9, 0, 0, 0, 1, 9, 0, 0);
    // T2: jump alone, then jump masked by load-use.
    cycle(0, 1, 2, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 5, 2, 0, 1, 0, 1, 5, 0, 0);
    cycle(0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    // T3: three-cycle memory wait, then ready, with a jump on the release cycle.
    memwait(3);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    idle(1);
    // T4: sixteen-cycle wait trips the timeout; error stays set afterwards.
    memwait(16);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fourteen stalls stay just under the timeout.
    memwait(14);
    idle(2);
    // T5: halt, drain with a two-cycle wait inside, then halted ignores mem_req.
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    memwait(2);
    cycle(0, 4, 4, 1, 1, 1, 1, 4, 0, 0);
    idle(3);
    memwait(3);
    // T6: reset mid-drain and mid-wait.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    memwait(5);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Random traffic with occasional long memory waits and resets.
    busy = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, req, rdy;
      r = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 3) == 0);
      if (busy == 0 && $urandom_range(0, 99) < 3) busy = $urandom_range(10, 20);
      if (busy > 0) begin
        req = 1; rdy = 0; busy--;
      end else begin
        req = ($urandom_range(0, 9) < 4);
        rdy = ($urandom_range(0, 1) == 1);
      end
      cycle(r, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 3),
            AW'($urandom_range(0, 7)), req, rdy);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
